// File: rtl/instr_mem_loader_ctrl.sv
// Instruction-memory port sequencer: streams a program into memory, zero-fills the
// remainder, then serves registered, alignment-checked CPU fetches while in RUN.
module instr_mem_loader_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_start_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              fetch_req_i,
  input  logic [31:0]       pc_addr_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  output logic              fetch_err_o,
  output logic              cpu_stall_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [AW:0]       word_cnt_o
);

  // Loader handshake: a word transfers on a rising edge where ld_valid_i and
  // ld_ready_o are both high; ld_ready_o is high only in LOAD and never depends on ld_valid_i.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  // Reset asserts asynchronously but is released two clocks after rst_n_i rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW:0]         word_cnt_q, word_cnt_d;
  logic                load_err_q, load_err_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                fetch_err_q, fetch_err_d;
  logic                pc_bad;

  // DEPTH is a power of two, so any set bit above the word index is out of range.
  assign pc_bad = (pc_addr_i[1:0] != 2'b00) || (pc_addr_i[31:AW+2] != '0);

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      word_cnt_q    <= '0;
      load_err_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_cnt_q    <= word_cnt_d;
      load_err_q    <= load_err_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_cnt_d    = word_cnt_q;
    load_err_d    = load_err_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    ld_ready_o    = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    cpu_stall_o   = 1'b1;
    load_done_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          state_d    = S_LOAD;
          cnt_d      = '0;
          word_cnt_d = '0;
          load_err_d = 1'b0;
        end
      end

      S_LOAD: begin
        ld_ready_o  = 1'b1;
        mem_addr_o  = cnt_q;
        mem_wdata_o = ld_data_i;
        mem_we_o    = ld_valid_i;
        if (ld_valid_i) begin
          cnt_d = cnt_q + AW'(1);
          if (word_cnt_q != DEPTH_CNT) word_cnt_d = word_cnt_q + (AW + 1)'(1);
          if (cnt_q == LAST_ADDR) begin
            // Memory is full: an unterminated program is flagged, never wrapped.
            state_d    = S_RUN;
            load_err_d = !ld_last_i;
          end else if (ld_last_i) begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        mem_we_o   = 1'b1;
        mem_addr_o = cnt_q;
        cnt_d      = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) state_d = S_RUN;
      end

      S_RUN: begin
        cpu_stall_o = 1'b0;
        load_done_o = 1'b1;
        mem_addr_o  = pc_addr_i[AW+1:2];
        if (fetch_req_i) begin
          instr_valid_d = 1'b1;
          if (pc_bad) begin
            instr_d     = '0;
            fetch_err_d = 1'b1;
          end else begin
            instr_d = mem_rdata_i;
          end
        end
        if (load_start_i) begin
          state_d    = S_LOAD;
          cnt_d      = '0;
          word_cnt_d = '0;
          load_err_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign fetch_err_o   = fetch_err_q;
  assign load_err_o    = load_err_q;
  assign word_cnt_o    = word_cnt_q;

endmodule

// File: doc/instr_mem_loader_ctrl.md
Name: instr_mem_loader_ctrl

Overview:
Sequencer that owns the single port of the instruction memory (32 words x 32 bits, asynchronous read, synchronous write).
- Boot/reprogram: accepts a program as a valid/ready word stream, writes it from word 0 upward, and zero-fills the rest of the memory.
- Run: releases the CPU and serves instruction fetches with a registered, alignment-checked read.
- CPU is held in stall whenever the memory is not in RUN.

Parameters:
DATA_W, 32, instruction/data word width
DEPTH, 32, memory depth in words (power of two)
AW, 5, memory word-address width, log2(DEPTH)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  reset; asynchronous, active-low
load_start_i  input  1  request (re)programming; sampled in IDLE and RUN only
ld_valid_i  input  1  loader word valid
ld_data_i  input  DATA_W  loader word
ld_last_i  input  1  current loader word is the final word of the program
ld_ready_o  output  1  controller accepts a loader word this cycle
fetch_req_i  input  1  CPU fetch request
pc_addr_i  input  32  CPU byte address
instr_o  output  DATA_W  fetched instruction (registered)
instr_valid_o  output  1  instr_o is valid this cycle
fetch_err_o  output  1  one-cycle pulse: last fetch was misaligned or out of range
cpu_stall_o  output  1  CPU must hold its PC
mem_we_o  output  1  memory write enable
mem_addr_o  output  AW  memory word address
mem_wdata_o  output  DATA_W  memory write data
mem_rdata_i  input  DATA_W  memory read data, combinational from mem_addr_o
load_done_o  output  1  high while in RUN
load_err_o  output  1  sticky: last program overflowed DEPTH without ld_last_i
word_cnt_o  output  AW+1  loader words accepted in the current/last load

Behaviour:
- States: IDLE, LOAD, FILL, RUN. Moore outputs are decoded from the state.
- Reset (async assert; release is synchronized by the design):
  - state = IDLE, internal counter cnt = 0.
  - Outputs: instr_o=0, instr_valid_o=0, fetch_err_o=0, load_err_o=0, word_cnt_o=0, load_done_o=0, ld_ready_o=0, mem_we_o=0, cpu_stall_o=1.
  - Reset mid-LOAD/FILL aborts the load; memory contents are then undefined, and the block waits in IDLE for a new load_start_i.
- IDLE:
  - cpu_stall_o=1.
  - load_start_i -> LOAD; cnt=0, word_cnt_o=0, load_err_o=0.
- LOAD:
  - ld_ready_o=1; mem_addr_o=cnt, mem_wdata_o=ld_data_i, mem_we_o=ld_valid_i.
  - Each accepted beat (ld_valid_i & ld_ready_o): cnt+1, word_cnt_o+1.
  - Accepted beat with ld_last_i and cnt<DEPTH-1 -> FILL with cnt+1.
  - Accepted beat with cnt==DEPTH-1 -> RUN. If ld_last_i=0 on that beat, load_err_o=1 and ld_ready_o=0 from the next cycle; excess stream words are never accepted.
  - No ld_valid_i: wait indefinitely, no timeout.
- FILL:
  - ld_ready_o=0; mem_we_o=1, mem_wdata_o=0, mem_addr_o=cnt, cnt+1 per cycle.
  - After writing DEPTH-1 -> RUN.
  - Fill duration is DEPTH-words_loaded cycles.
- RUN:
  - cpu_stall_o=0, load_done_o=1, mem_we_o=0, mem_addr_o=pc_addr_i[AW+1:2].
  - fetch_req_i: next cycle instr_valid_o=1 and instr_o=mem_rdata_i (latency 1).
  - If pc_addr_i[1:0]!=0 or pc_addr_i>=DEPTH*4: instr_o=0 (NOP) and fetch_err_o=1 for that cycle instead.
  - No fetch_req_i: instr_valid_o=0, instr_o holds its previous value.
  - load_start_i -> LOAD. A fetch in the same cycle is still completed (valid the next cycle). cpu_stall_o=1 from the next cycle.
- load_start_i in LOAD/FILL is ignored. fetch_req_i outside RUN is ignored: no instr_valid_o, no error.
- word_cnt_o saturates at DEPTH and holds after the load. load_err_o holds until the next load_start_i or reset.

Test Plan:
- Reset, load_start_i, stream 3 words 0x20080005, 0x20090007, 0x01095020 (last on 3rd) -> 3 writes at addr 0..2, then 29 zero writes at addr 3..31, load_done_o=1, word_cnt_o=3.
- After that load, fetch pc 0x4 -> next cycle instr_valid_o=1, instr_o=0x20090007. Fetch pc 0x40 -> instr_o=0.
- Fetch pc 0x6 -> instr_o=0, fetch_err_o pulse. Fetch pc 0x80 -> instr_o=0, fetch_err_o pulse.
- Stream 33 words with no ld_last_i -> 32 accepted, load_err_o=1, word_cnt_o=32, ld_ready_o low, 33rd word never accepted, RUN entered.
- ld_valid_i toggling 1,0,1,0 in LOAD -> writes only on valid cycles, addresses contiguous.
- Assert rst_n_i low after 2 accepted beats -> immediate IDLE, cpu_stall_o=1, load_done_o=0. Then load_start_i in RUN while fetching pc 0x0 -> fetch completes, stall asserts the next cycle.
